// File: rtl/dcache_mem_bridge_pkg.sv
// dcache_mem_bridge_pkg: shared state encoding, access sizes and line width helper
package dcache_mem_bridge_pkg;
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, RESP} state_e;
  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  function automatic int line_bits(input int ow);
    return 32 << ow;
  endfunction
endpackage

// File: rtl/dcache_mem_bridge_if.sv
// dcache_mem_bridge_if: Dcache request/response port plus word-wide backing bus
interface dcache_mem_bridge_if
  import dcache_mem_bridge_pkg::*;
#(
  parameter int offset_width = 2
) ();
  localparam int LINE_BITS = line_bits(offset_width);
  logic                 dcache_mem_req;
  logic                 dcache_mem_wr;
  logic                 dcache_mem_SUC;
  logic [1:0]           dcache_mem_size;
  logic [3:0]           dcache_mem_wstrb;
  logic [31:0]          addr_dcache_mem;
  logic [31:0]          pc_dcache_mem;
  logic [31:0]          dout_dcache_mem;
  logic [LINE_BITS-1:0] din_mem_dcache;
  logic                 mem_dcache_addrOK;
  logic                 mem_dcache_dataOK;
  logic                 bus_req;
  logic                 bus_we;
  logic [31:0]          bus_addr;
  logic [31:0]          bus_wdata;
  logic [3:0]           bus_wstrb;
  logic [1:0]           bus_size;
  logic                 bus_ready;
  logic                 bus_rvalid;
  logic [31:0]          bus_rdata;
  modport slave (
    input  dcache_mem_req, dcache_mem_wr, dcache_mem_SUC, dcache_mem_size, dcache_mem_wstrb,
           addr_dcache_mem, pc_dcache_mem, dout_dcache_mem, bus_ready, bus_rvalid, bus_rdata,
    output din_mem_dcache, mem_dcache_addrOK, mem_dcache_dataOK,
           bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb, bus_size
  );
  modport master (
    output dcache_mem_req, dcache_mem_wr, dcache_mem_SUC, dcache_mem_size, dcache_mem_wstrb,
           addr_dcache_mem, pc_dcache_mem, dout_dcache_mem, bus_ready, bus_rvalid, bus_rdata,
    input  din_mem_dcache, mem_dcache_addrOK, mem_dcache_dataOK,
           bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb, bus_size
  );
endinterface

// File: rtl/dcache_mem_bridge_linebuf.sv
// dcache_mem_bridge_linebuf: word-indexed refill line register
module dcache_mem_bridge_linebuf #(
  parameter int offset_width = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              we_i,
  input  logic [offset_width-1:0]           idx_i,
  input  logic [31:0]                       wdata_i,
  output logic [32*(1<<offset_width)-1:0]   line_o
);
  logic [32*(1<<offset_width)-1:0] line_q;
  always_ff @(posedge clk) begin
    if (rst) line_q <= '0;
    else if (we_i) line_q[idx_i*32 +: 32] <= wdata_i;
  end
  assign line_o = line_q;
endmodule

// File: rtl/dcache_mem_bridge.sv
// dcache_mem_bridge: serves Dcache line/word requests as single-word backing-bus transactions
module dcache_mem_bridge
  import dcache_mem_bridge_pkg::*;
#(
  parameter int offset_width = 2
) (
  input logic                clk,
  input logic                rst,
  dcache_mem_bridge_if.slave m
);
  localparam int line_words = 1 << offset_width;
  state_e                  state_q, state_d;
  logic [offset_width-1:0] cnt_q, cnt_d;
  logic [31:0]             addr_q, wdata_q, pc_unused_q;
  logic                    suc_q;
  logic [1:0]              size_q;
  logic [3:0]              wstrb_q;
  logic                    accept, rd_beat, last_beat, bus_act, wr_act;
  assign accept    = state_q == IDLE && m.dcache_mem_req;
  assign rd_beat   = state_q == RD_WAIT && m.bus_rvalid;
  assign last_beat = suc_q || cnt_q == offset_width'(line_words - 1);
  assign bus_act   = state_q == RD_REQ || state_q == WR_REQ;
  assign wr_act    = state_q == WR_REQ;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      pc_unused_q <= '0;
      suc_q       <= 1'b0;
      size_q      <= '0;
      wstrb_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q      <= m.addr_dcache_mem;
        wdata_q     <= m.dout_dcache_mem;
        pc_unused_q <= m.pc_dcache_mem;
        suc_q       <= m.dcache_mem_SUC;
        size_q      <= m.dcache_mem_size;
        wstrb_q     <= m.dcache_mem_wstrb;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = m.dcache_mem_wr ? WR_REQ : RD_REQ;
      RD_REQ:  if (m.bus_ready) state_d = RD_WAIT;
      RD_WAIT: if (m.bus_rvalid) begin
        state_d = last_beat ? RESP : RD_REQ;
        cnt_d   = last_beat ? cnt_q : cnt_q + offset_width'(1);
      end
      WR_REQ:  if (m.bus_ready) state_d = RESP;
      RESP: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  // Bus fields are forced to zero outside request states so idle/reset outputs read as 0
  assign m.mem_dcache_addrOK = accept;
  assign m.mem_dcache_dataOK = state_q == RESP;
  assign m.bus_req   = bus_act;
  assign m.bus_we    = wr_act;
  assign m.bus_addr  = !bus_act ? '0 : (suc_q || wr_act) ? addr_q : {addr_q[31:2+offset_width], cnt_q, 2'b00};
  assign m.bus_size  = !bus_act ? '0 : (suc_q || wr_act) ? size_q : SIZE_W;
  assign m.bus_wdata = wr_act ? wdata_q : '0;
  assign m.bus_wstrb = wr_act ? wstrb_q : '0;
  dcache_mem_bridge_linebuf #(.offset_width(offset_width)) u_linebuf (
    .clk    (clk),
    .rst    (rst),
    .we_i   (rd_beat),
    .idx_i  (suc_q ? '0 : cnt_q),
    .wdata_i(m.bus_rdata),
    .line_o (m.din_mem_dcache)
  );
endmodule

// File: tb/tb_dcache_mem_bridge.sv
// tb_dcache_mem_bridge: directed scoreboard bench with a behavioural backing-bus responder
module tb_dcache_mem_bridge;
  import dcache_mem_bridge_pkg::*;
  typedef struct packed {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } bus_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  dcache_mem_bridge_if #(.offset_width(2)) b ();
  dcache_mem_bridge #(.offset_width(2)) dut (.clk(clk), .rst(rst), .m(b));
  int n_chk = 0, n_fail = 0, cyc = 0, last_hs = -10, ready_delay = 0, wait_n = 0;
  logic stray = 1'b0, hs_we = 1'b0, t_ready = 1'b0, t_rvalid = 1'b0;
  logic [31:0] bias = '0, hs_addr = '0, t_rdata = '0;
  logic [127:0] exp_line = '0;
  bus_t exp_q[$];
  bus_t prev_bus = '0;
  logic prev_stall = 1'b0;
  assign b.bus_ready  = t_ready;
  assign b.bus_rvalid = t_rvalid;
  assign b.bus_rdata  = t_rdata;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h1FE0_0004) ? 32'h0000_0055 : 32'hA0 + bias + {30'd0, a[3:2]};
  endfunction
  function automatic logic [127:0] line_of(input logic [31:0] bs);
    logic [127:0] l;
    for (int i = 0; i < 4; i++) l[i*32 +: 32] = 32'hA0 + bs + 32'(i);
    return l;
  endfunction
  function automatic bus_t cur_bus();
    return {b.bus_req, b.bus_we, b.bus_addr, b.bus_size, b.bus_wstrb, b.bus_wdata};
  endfunction
  function automatic bus_t mk_bus(input logic we, input logic [31:0] a, input logic [1:0] sz,
                                  input logic [3:0] st, input logic [31:0] d);
    return {1'b1, we, a, sz, st, d};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push_line(input logic [31:0] a);
    for (int i = 0; i < 4; i++) exp_q.push_back(mk_bus(1'b0, {a[31:4], 2'(i), 2'b00}, SIZE_W, 4'h0, 32'h0));
  endtask

  task automatic issue(input logic wr, input logic suc, input logic [1:0] sz, input logic [3:0] st,
                       input logic [31:0] a, input logic [31:0] d);
    logic acc;
    acc = 1'b0;
    @(posedge clk); #1;
    b.dcache_mem_wr    = wr;
    b.dcache_mem_SUC   = suc;
    b.dcache_mem_size  = sz;
    b.dcache_mem_wstrb = st;
    b.addr_dcache_mem  = a;
    b.dout_dcache_mem  = d;
    b.pc_dcache_mem    = 32'hBFC0_1000 + a;
    b.dcache_mem_req   = 1'b1;
    for (int i = 0; i < 40 && !acc; i++) begin
      @(negedge clk);
      acc = b.mem_dcache_addrOK;
    end
    chk("accept", acc, 1);
    @(posedge clk); #1;
    b.dcache_mem_req = 1'b0;
  endtask

  // n counts cycles with the accept cycle as cycle 1
  task automatic wait_done(output int n);
    logic done;
    done = 1'b0;
    n = 1;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      n++;
      done = b.mem_dcache_dataOK;
    end
    chk("dataok_seen", done, 1);
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #2;
    t_rvalid = (t_ready && !hs_we) || stray;
    t_rdata  = (t_ready && !hs_we) ? mem_word(hs_addr) : 32'hDEAD_BEEF;
    if (t_ready) begin
      t_ready = 1'b0;
      wait_n  = 0;
    end else if (b.bus_req) begin
      if (wait_n >= ready_delay) begin
        t_ready = 1'b1;
        hs_we   = b.bus_we;
        hs_addr = b.bus_addr;
      end else wait_n++;
    end
  end

  always @(negedge clk) begin
    bus_t cur;
    cur = cur_bus();
    if (!rst) begin
      if (prev_stall) chk("bus_stable", cur, prev_bus);
      if (b.bus_req && b.bus_ready) begin
        last_hs = cyc;
        if (exp_q.size() == 0) chk("bus_unexpected", cur, 0);
        else chk("bus_txn", cur, exp_q.pop_front());
      end
    end
    prev_stall = !rst && b.bus_req && !b.bus_ready;
    prev_bus   = cur;
  end

  initial begin
    int n, hs;
    b.dcache_mem_req   = 1'b0;
    b.dcache_mem_wr    = 1'b0;
    b.dcache_mem_SUC   = 1'b0;
    b.dcache_mem_size  = 2'd0;
    b.dcache_mem_wstrb = 4'h0;
    b.addr_dcache_mem  = '0;
    b.pc_dcache_mem    = '0;
    b.dout_dcache_mem  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outs", {b.mem_dcache_addrOK, b.mem_dcache_dataOK, cur_bus()}, 0);
    chk("rst_line", b.din_mem_dcache, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    bias = 32'h0;
    push_line(32'h0000_1230);
    issue(1'b0, 1'b0, SIZE_W, 4'h0, 32'h0000_1234, 32'h0);
    wait_done(n);
    chk("rd_latency", n, 10);
    exp_line = line_of(32'h0);
    chk("rd_line", b.din_mem_dcache, exp_line);
    @(negedge clk);
    chk("rd_dataok_once", b.mem_dcache_dataOK, 0);
    chk("rd_line_hold1", b.din_mem_dcache, exp_line);
    @(negedge clk);
    chk("rd_line_hold2", b.din_mem_dcache, exp_line);
    chk("rd_sb_empty", exp_q.size(), 0);

    exp_q.push_back(mk_bus(1'b0, 32'h1FE0_0004, SIZE_B, 4'h0, 32'h0));
    issue(1'b0, 1'b1, SIZE_B, 4'h0, 32'h1FE0_0004, 32'h0);
    wait_done(n);
    chk("suc_latency", n, 4);
    exp_line[31:0] = 32'h0000_0055;
    chk("suc_line", b.din_mem_dcache, exp_line);
    chk("suc_sb_empty", exp_q.size(), 0);

    ready_delay = 3;
    exp_q.push_back(mk_bus(1'b1, 32'h8000_0010, SIZE_B, 4'b0010, 32'h0000_AB00));
    issue(1'b1, 1'b0, SIZE_B, 4'b0010, 32'h8000_0010, 32'h0000_AB00);
    wait_done(n);
    chk("wr_resp_gap", cyc - last_hs, 1);
    chk("wr_line_kept", b.din_mem_dcache, exp_line);
    chk("wr_sb_empty", exp_q.size(), 0);
    ready_delay = 0;

    repeat (2) exp_q.push_back(mk_bus(1'b1, 32'h0000_0100, SIZE_W, 4'hF, 32'h0000_0011));
    @(posedge clk); #1;
    b.dcache_mem_wr    = 1'b1;
    b.dcache_mem_SUC   = 1'b0;
    b.dcache_mem_size  = SIZE_W;
    b.dcache_mem_wstrb = 4'hF;
    b.addr_dcache_mem  = 32'h0000_0100;
    b.dout_dcache_mem  = 32'h0000_0011;
    b.dcache_mem_req   = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("hold_addrok", b.mem_dcache_addrOK, (k % 3) == 0);
      chk("hold_dataok", b.mem_dcache_dataOK, (k % 3) == 2);
    end
    @(posedge clk); #1;
    b.dcache_mem_req = 1'b0;
    chk("hold_sb_empty", exp_q.size(), 0);

    @(posedge clk); #1;
    stray = 1'b1;
    @(negedge clk);
    chk("stray_idle_dataok", b.mem_dcache_dataOK, 0);
    @(posedge clk); #1;
    stray = 1'b0;
    @(negedge clk);
    chk("stray_idle_line", b.din_mem_dcache, exp_line);

    ready_delay = 3;
    exp_q.push_back(mk_bus(1'b1, 32'h0000_0040, SIZE_W, 4'hF, 32'h1234_5678));
    issue(1'b1, 1'b0, SIZE_W, 4'hF, 32'h0000_0040, 32'h1234_5678);
    stray = 1'b1;
    @(negedge clk);
    chk("stray_wr_dataok", b.mem_dcache_dataOK, 0);
    @(posedge clk); #1;
    stray = 1'b0;
    wait_done(n);
    chk("stray_wr_line", b.din_mem_dcache, exp_line);
    ready_delay = 0;

    bias = 32'h20;
    push_line(32'h0000_3000);
    issue(1'b0, 1'b0, SIZE_W, 4'h0, 32'h0000_3004, 32'h0);
    hs = 0;
    for (int i = 0; i < 40 && hs < 3; i++) begin
      @(negedge clk);
      if (b.bus_req && b.bus_ready) hs++;
    end
    chk("rst_third_hs", hs, 3);
    @(posedge clk); #1;
    rst   = 1'b1;
    stray = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_outs", {b.mem_dcache_addrOK, b.mem_dcache_dataOK, cur_bus()}, 0);
    chk("rst_mid_line", b.din_mem_dcache, 0);
    @(posedge clk); #1;
    stray = 1'b0;
    @(negedge clk);
    chk("rst_late_outs", {b.mem_dcache_addrOK, b.mem_dcache_dataOK, cur_bus()}, 0);
    chk("rst_late_line", b.din_mem_dcache, 0);
    chk("rst_sb_left", exp_q.size(), 1);
    exp_q.delete();

    bias = 32'h10;
    push_line(32'h0000_2000);
    issue(1'b0, 1'b0, SIZE_W, 4'h0, 32'h0000_2008, 32'h0);
    wait_done(n);
    chk("rd2_latency", n, 10);
    exp_line = line_of(32'h10);
    chk("rd2_line", b.din_mem_dcache, exp_line);
    chk("final_sb_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
